// File: rtl/alu_exec_stage.sv
// RV32I/RV64I execute stage with a registered, valid/ready result port.
// Shifts iterate one bit per cycle unless ALU_BARREL_SHIFT_EN is defined.
module alu_exec_stage #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [SHW-1:0] SH_ZERO = {SHW{1'b0}};

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_shift_out;
  logic [XLEN-1:0] w_res;
  logic            w_accept;
  logic            w_write_now;

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  assign w_shamt   = op_b[SHW-1:0];
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_valid;
  assign result    = r_result;
  assign rd_out    = r_rd_out;

`ifdef ALU_BARREL_SHIFT_EN

  assign in_ready    = !r_valid || out_ready;
  assign busy        = 1'b0;
  assign w_write_now = w_accept;

  // Full-width barrel shift for SLL/SRL/SRA
  always_comb begin
    w_shift_out = op_a;
    case (alu_op)
      OP_SLL:  w_shift_out = op_a << w_shamt;
      OP_SRL:  w_shift_out = op_a >> w_shamt;
      OP_SRA:  w_shift_out = $signed(op_a) >>> w_shamt;
      default: w_shift_out = op_a;
    endcase
  end

  // Output register: load on accept, drop valid when consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= {XLEN{1'b0}};
      r_rd_out <= 5'd0;
    end else if (w_write_now) begin
      r_valid  <= 1'b1;
      r_result <= w_res;
      r_rd_out <= rd_in;
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end else begin
      r_valid  <= r_valid;
    end
  end

`else

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam logic [SHW-1:0] SH_ONE = {{(SHW-1){1'b0}}, 1'b1};

  logic [0:0]      r_state;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_sh;
  logic [3:0]      r_op;
  logic [4:0]      r_rd;
  logic            w_is_shift;
  logic            w_long_shift;
  logic            w_shift_done;

  // One-bit step of the selected shift; also used for amount-1 shifts
  function automatic logic [XLEN-1:0] shift1(input logic [3:0] op, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] s;
    case (op)
      OP_SLL:  s = {v[XLEN-2:0], 1'b0};
      OP_SRL:  s = {1'b0, v[XLEN-1:1]};
      OP_SRA:  s = {v[XLEN-1], v[XLEN-1:1]};
      default: s = v;
    endcase
    return s;
  endfunction

  assign w_is_shift   = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
  assign w_long_shift = w_is_shift && (w_shamt > SH_ONE);
  assign w_write_now  = w_accept && !w_long_shift;
  assign w_shift_done = (r_state == S_SHIFT) && (r_cnt == SH_ONE);
  assign in_ready     = (r_state == S_IDLE) && (!r_valid || out_ready);
  assign busy         = (r_state == S_SHIFT);

  // Amount 0 passes op_a through; amount 1 completes in the accept cycle
  always_comb begin
    if (w_shamt == SH_ZERO) begin
      w_shift_out = op_a;
    end else begin
      w_shift_out = shift1(alu_op, op_a);
    end
  end

  // Iterative shifter: first step taken at accept, one step per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= SH_ZERO;
      r_sh    <= {XLEN{1'b0}};
      r_op    <= 4'd0;
      r_rd    <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_long_shift) begin
            r_state <= S_SHIFT;
            r_cnt   <= w_shamt - SH_ONE;
            r_sh    <= shift1(alu_op, op_a);
            r_op    <= alu_op;
            r_rd    <= rd_in;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_sh  <= shift1(r_op, r_sh);
          r_cnt <= r_cnt - SH_ONE;
          if (r_cnt == SH_ONE) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= SH_ZERO;
        end
      endcase
    end
  end

  // Output register: single-cycle results or final shift step, else drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= {XLEN{1'b0}};
      r_rd_out <= 5'd0;
    end else if (w_write_now) begin
      r_valid  <= 1'b1;
      r_result <= w_res;
      r_rd_out <= rd_in;
    end else if (w_shift_done) begin
      r_valid  <= 1'b1;
      r_result <= shift1(r_op, r_sh);
      r_rd_out <= r_rd;
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end else begin
      r_valid  <= r_valid;
    end
  end

`endif

  // Single-cycle result mux; codes 10-15 fall through to ADD
  always_comb begin
    w_res = op_a + op_b;
    case (alu_op)
      OP_ADD:  w_res = op_a + op_b;
      OP_SUB:  w_res = op_a - op_b;
      OP_SLL:  w_res = w_shift_out;
      OP_SRL:  w_res = w_shift_out;
      OP_SRA:  w_res = w_shift_out;
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  w_res = op_a ^ op_b;
      OP_OR:   w_res = op_a | op_b;
      OP_AND:  w_res = op_a & op_b;
      default: w_res = op_a + op_b;
    endcase
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus a randomized
// run against a cycle-level reference model of the handshake and ALU rules.
module tb_alu_exec_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_out(rd_out), .busy(busy)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return 32'($signed(a) >>> sh);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    int n;
    n = int'(b % 32);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == 4'd2 || op == 4'd6 || op == 4'd7) && n >= 2) return n;
    return 1;
`endif
  endfunction

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b; rd_in = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 4'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    #2;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags got v=%b b=%b exp 0 0", out_valid, busy); end
    checks++; if (result !== 32'd0 || rd_out !== 5'd0) begin failures++; $display("FAIL reset_regs got r=%h rd=%0d exp 0 0", result, rd_out); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL post_reset got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    logic [31:0] exps [3];
    ops = '{4'd0, 4'd0, 4'd1}; as = '{32'd5, 32'hFFFF_FFFF, 32'd3};
    bs = '{32'd7, 32'd1, 32'd5}; exps = '{32'd12, 32'd0, 32'hFFFF_FFFE};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(ops[i], as[i], bs[i], 5'(i + 1));
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== exps[i] || rd_out !== 5'(i + 1)) begin
        failures++; $display("FAIL b2b_result[%0d] got v=%b r=%h rd=%0d exp 1 %h %0d", i, out_valid, result, rd_out, exps[i], i + 1);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sra_iterative();
    int lat;
    out_ready = 1'b1;
    set_op(4'd7, 32'h8000_0000, 32'd4, 5'd7);
    @(posedge clk); #1;
    set_op(4'd0, 32'd1, 32'd1, 5'd9);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL sra_busy[%0d] got busy=%b rdy=%b exp 1 0", lat, busy, in_ready); end
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != ref_lat(4'd7, 32'd4)) begin failures++; $display("FAIL sra_latency got=%0d exp=%0d", lat, ref_lat(4'd7, 32'd4)); end
    checks++; if (result !== 32'hF800_0000 || rd_out !== 5'd7 || busy !== 1'b0) begin failures++; $display("FAIL sra_result got r=%h rd=%0d b=%b exp f8000000 7 0", result, rd_out, busy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd2 || rd_out !== 5'd9) begin failures++; $display("FAIL sra_next got v=%b r=%h rd=%0d exp 1 2 9", out_valid, result, rd_out); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_shift_boundaries();
    int lat;
    out_ready = 1'b1;
    set_op(4'd2, 32'h1234_5678, 32'h20, 5'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'h1234_5678) begin failures++; $display("FAIL sll_amt0 got v=%b r=%h exp 1 12345678", out_valid, result); end
    set_op(4'd2, 32'h1234_5678, 32'd1, 5'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'h2468_ACF0) begin failures++; $display("FAIL sll_amt1 got v=%b r=%h exp 1 2468acf0", out_valid, result); end
    @(posedge clk); #1;
    set_op(4'd6, 32'h8000_0000, 32'd31, 5'd31);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != ref_lat(4'd6, 32'd31)) begin failures++; $display("FAIL srl31_latency got=%0d exp=%0d", lat, ref_lat(4'd6, 32'd31)); end
    checks++; if (result !== 32'd1 || rd_out !== 5'd31) begin failures++; $display("FAIL srl31_result got r=%h rd=%0d exp 1 31", result, rd_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_op(4'd4, 32'd1, 32'hFFFF_FFFF, 5'd5);
    @(posedge clk); #1;
    set_op(4'd0, 32'd10, 32'd20, 5'd6);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd1 || rd_out !== 5'd5 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b r=%h rd=%0d rdy=%b exp 1 1 5 0", i, out_valid, result, rd_out, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd30 || rd_out !== 5'd6) begin failures++; $display("FAIL bp_next got v=%b r=%h rd=%0d exp 1 30 6", out_valid, result, rd_out); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_slt_illegal();
    logic [3:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    logic [31:0] exps [3];
    ops = '{4'd3, 4'd3, 4'd12}; as = '{32'hFFFF_FFFF, 32'd1, 32'd2};
    bs = '{32'd1, 32'hFFFF_FFFF, 32'd3}; exps = '{32'd1, 32'd0, 32'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(ops[i], as[i], bs[i], 5'(20 + i));
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || result !== exps[i]) begin failures++; $display("FAIL slt_illegal[%0d] got v=%b r=%h exp 1 %h", i, out_valid, result, exps[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midshift();
    out_ready = 1'b1;
    set_op(4'd2, 32'd1, 32'd10, 5'd11);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midshift_reset got v=%b b=%b r=%h rd=%0d rdy=%b exp 0 0 0 0 1", out_valid, busy, result, rd_out, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midshift_stale[%0d] got v=%b b=%b exp 0 0", i, out_valid, busy); end
    end
  endtask

  task automatic test_random();
    logic        m_valid = 1'b0;
    logic [31:0] m_result = 32'd0;
    logic [4:0]  m_rd = 5'd0;
    int          m_pend = 0;
    logic [31:0] m_pres = 32'd0;
    logic [4:0]  m_prd = 5'd0;
    logic        exp_ready;
    logic        wr;
    int          lat;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      alu_op = 4'($urandom_range(0, 15));
      op_a = $urandom;
      op_b = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 5));
      rd_in = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (m_pend == 0) && (!m_valid || out_ready);
      checks++; if (in_ready !== exp_ready || busy !== (m_pend > 0)) begin failures++; $display("FAIL rand_ready[%0d] got rdy=%b b=%b exp %b %b", cyc, in_ready, busy, exp_ready, m_pend > 0); end
      @(posedge clk);
      wr = 1'b0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin wr = 1'b1; m_result = m_pres; m_rd = m_prd; end
      end else if (in_valid && exp_ready) begin
        lat = ref_lat(alu_op, op_b);
        if (lat == 1) begin
          wr = 1'b1; m_result = ref_alu(alu_op, op_a, op_b); m_rd = rd_in;
        end else begin
          m_pend = lat - 1; m_pres = ref_alu(alu_op, op_a, op_b); m_prd = rd_in;
        end
      end
      if (wr) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
      #1;
      checks++; if (out_valid !== m_valid) begin failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", cyc, out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (result !== m_result || rd_out !== m_rd) begin failures++; $display("FAIL rand_result[%0d] got r=%h rd=%0d exp %h %0d", cyc, result, rd_out, m_result, m_rd); end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sra_iterative();
    test_shift_boundaries();
    test_backpressure();
    test_slt_illegal();
    test_reset_midshift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
